count_wrap_monitor: RTL and testbench
=====================================

Name: count_wrap_monitor

Overview:
- Downstream consumer of the 4-bit up/down counter output; samples the count every clock and classifies each transition as up-step, down-step, hold or illegal jump.
- Flags wrap-around in both directions, keeps a signed wrap-epoch count, and tracks threshold crossings with hold-on-equal hysteresis.
- Feeds status logic and display stages that need to know more than the raw 4-bit value.

Parameters:
- W, 4, count width; must match upstream counter width.
- EPOCH_W, 8, width of the signed wrap-epoch register (two's complement).

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cnt_in  in  W  count value from upstream counter, sampled every cycle
- clr  in  1  synchronous clear; same effect as reset, but taken on the clock edge
- thr  in  W  unsigned threshold for the above/below tracker
- valid  out  1  high once a previous sample exists and the classification outputs are meaningful
- dir  out  1  last non-hold direction: 1 = up, 0 = down
- stall  out  1  pulse: cnt_in equals the previous sample
- wrap_up  out  1  pulse: transition from 2^W-1 to 0
- wrap_dn  out  1  pulse: transition from 0 to 2^W-1
- jump_err  out  1  sticky: an illegal transition has occurred
- epoch  out  EPOCH_W  signed net wrap count
- above  out  1  hysteresis threshold state

Behaviour:
- Reset (rst, or clr on an edge): FSM to PRIME. prev=0, valid=0, dir=1, stall=0, wrap_up=0, wrap_dn=0, jump_err=0, epoch=0, above=0.
- FSM states:
  - PRIME: on the next edge, capture cnt_in into prev and set above = (cnt_in > thr). Go to TRACK and set valid=1. No pulse outputs fire in PRIME.
  - TRACK: every edge, compute delta = cnt_in - prev modulo 2^W, then update prev with cnt_in.
- Classification in TRACK (registered; each output reflects the sample taken one cycle earlier):
  - delta == 1: up-step. dir=1. wrap_up=1 if prev == 2^W-1.
  - delta == 2^W-1: down-step. dir=0. wrap_dn=1 if prev == 0.
  - delta == 0: stall=1; dir holds.
  - Any other delta: jump_err set (sticky until rst/clr); dir holds; no wrap pulses.
- Pulse outputs are single-cycle and mutually exclusive within a cycle.
- Epoch:
  - +1 on wrap_up, -1 on wrap_dn.
  - Saturates at +2^(EPOCH_W-1)-1 and -2^(EPOCH_W-1); no wrap.
  - Updates in the same cycle as the pulse.
- Above tracker (TRACK only):
  - cnt_in > thr sets above; cnt_in < thr clears it; cnt_in == thr holds.
  - thr may change at any time and is used combinationally on the sampling edge.
- clr and rst take precedence over all updates. Asserting clr mid-stream forces PRIME, so the following sample is never classified against a stale prev.
- Arithmetic: delta is a W-bit unsigned subtraction with the borrow discarded. All compares on cnt_in, prev and thr are unsigned.

Decomposition:
- Shared package:
  - state enum {PRIME, TRACK}
  - transition-class enum {STEP_UP, STEP_DN, HOLD, JUMP}
  - EPOCH_MAX / EPOCH_MIN derived from EPOCH_W
- One sub-module: sat_updown_ctr (signed saturating ±1 counter, parameter EPOCH_W), used for epoch.
- Transition classifier stays inline.

Test Plan:
- Reset then cnt_in 3,4,5 with thr=4:
  - valid rises after the first edge; dir=1; no pulses.
  - above=0 at 3, holds 0 at 4 (equal), goes 1 at 5.
- cnt_in 14,15,0,1:
  - wrap_up pulses exactly one cycle, after the 15→0 sample; epoch 0→1.
  - Then 1,0,15: wrap_dn pulses once; epoch back to 0.
- Hold 7,7,7 then 6:
  - stall high for two cycles.
  - dir holds its previous value until the 7→6 sample, then dir=0.
- cnt_in 2 then 9:
  - jump_err=1 with no wrap pulses and epoch unchanged.
  - jump_err stays 1 through further legal steps; pulse clr → jump_err=0, valid=0, next sample re-primes.
- Force 130 consecutive up-wraps (EPOCH_W=8): epoch saturates at 127.
  - 300 down-wraps → saturates at -128.
- Assert rst asynchronously mid-cycle during a 15→0 transition:
  - all outputs clear immediately, no wrap_up pulse; epoch=0.

Source files
------------

// File: rtl/count_wrap_monitor_pkg.sv
// ============================================================================
// Module : count_wrap_monitor_pkg
// Brief  : Shared state/transition types and epoch bound helpers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package count_wrap_monitor_pkg;

    typedef enum logic [0:0] {
        ST_PRIME = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        TR_STEP_UP = 2'd0,
        TR_STEP_DN = 2'd1,
        TR_HOLD    = 2'd2,
        TR_JUMP    = 2'd3
    } trans_t;

    // Two's-complement limits of an EPOCH_W-bit signed register.
    function automatic int epoch_max(input int epoch_w);
        return (2 ** (epoch_w - 1)) - 1;
    endfunction

    function automatic int epoch_min(input int epoch_w);
        return -(2 ** (epoch_w - 1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_updown_ctr.sv
// ============================================================================
// Module : sat_updown_ctr
// Brief  : Signed +/-1 counter that saturates at the two's-complement limits.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sat_updown_ctr
    import count_wrap_monitor_pkg::*;
#(
    parameter int EPOCH_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clr,
    input  logic                      i_inc,
    input  logic                      i_dec,
    output logic signed [EPOCH_W-1:0] o_val
);

    localparam logic signed [EPOCH_W-1:0] C_EPOCH_MAX = EPOCH_W'(epoch_max(EPOCH_W));
    localparam logic signed [EPOCH_W-1:0] C_EPOCH_MIN = EPOCH_W'(epoch_min(EPOCH_W));
    localparam logic signed [EPOCH_W-1:0] C_ONE       = EPOCH_W'(1);

    logic signed [EPOCH_W-1:0] r_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val <= '0;
        end else if (i_clr) begin
            r_val <= '0;
        end else if (i_inc && !i_dec && (r_val != C_EPOCH_MAX)) begin
            r_val <= r_val + C_ONE;
        end else if (i_dec && !i_inc && (r_val != C_EPOCH_MIN)) begin
            r_val <= r_val - C_ONE;
        end
    end

    assign o_val = r_val;

endmodule

`default_nettype wire

// File: rtl/count_wrap_monitor.sv
// ============================================================================
// Module : count_wrap_monitor
// Brief  : Classifies counter transitions, flags wraps, tracks wrap epoch
//          and threshold state with hold-on-equal hysteresis.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module count_wrap_monitor
    import count_wrap_monitor_pkg::*;
#(
    parameter int W       = 4,
    parameter int EPOCH_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [W-1:0]              cnt_in,
    input  logic                      clr,
    input  logic [W-1:0]              thr,
    output logic                      valid,
    output logic                      dir,
    output logic                      stall,
    output logic                      wrap_up,
    output logic                      wrap_dn,
    output logic                      jump_err,
    output logic signed [EPOCH_W-1:0] epoch,
    output logic                      above
);

    localparam logic [W-1:0] C_ALL_ONES = '1;
    localparam logic [W-1:0] C_ZERO     = '0;
    localparam logic [W-1:0] C_ONE      = W'(1);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_prev;
    logic         r_valid;
    logic         r_dir;
    logic         r_stall;
    logic         r_wrap_up;
    logic         r_wrap_dn;
    logic         r_jump_err;
    logic         r_above;

    logic [W-1:0] w_delta;
    trans_t       w_class;
    logic         w_track;
    logic         w_wrap_up_nxt;
    logic         w_wrap_dn_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_PRIME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ST_PRIME;
        end else if (r_state == ST_PRIME) begin
            w_state_nxt = ST_TRACK;
        end
    end

    // Modular difference: the borrow is dropped so 15->0 reads as +1.
    always_comb begin
        w_delta = cnt_in - r_prev;
        w_class = TR_JUMP;
        if (w_delta == C_ONE) begin
            w_class = TR_STEP_UP;
        end else if (w_delta == C_ALL_ONES) begin
            w_class = TR_STEP_DN;
        end else if (w_delta == C_ZERO) begin
            w_class = TR_HOLD;
        end
    end

    assign w_track       = (r_state == ST_TRACK) && !clr;
    assign w_wrap_up_nxt = w_track && (w_class == TR_STEP_UP) && (r_prev == C_ALL_ONES);
    assign w_wrap_dn_nxt = w_track && (w_class == TR_STEP_DN) && (r_prev == C_ZERO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            r_prev     <= '0;
            r_valid    <= 1'b0;
            r_dir      <= 1'b1;
            r_stall    <= 1'b0;
            r_wrap_up  <= 1'b0;
            r_wrap_dn  <= 1'b0;
            r_jump_err <= 1'b0;
            r_above    <= 1'b0;
        end else if (r_state == ST_PRIME) begin
            r_prev    <= cnt_in;
            r_valid   <= 1'b1;
            r_stall   <= 1'b0;
            r_wrap_up <= 1'b0;
            r_wrap_dn <= 1'b0;
            r_above   <= (cnt_in > thr);
        end else begin
            r_prev    <= cnt_in;
            r_stall   <= (w_class == TR_HOLD);
            r_wrap_up <= w_wrap_up_nxt;
            r_wrap_dn <= w_wrap_dn_nxt;
            if (w_class == TR_STEP_UP) begin
                r_dir <= 1'b1;
            end else if (w_class == TR_STEP_DN) begin
                r_dir <= 1'b0;
            end
            if (w_class == TR_JUMP) begin
                r_jump_err <= 1'b1;
            end
            // Equal to threshold holds the previous state.
            if (cnt_in > thr) begin
                r_above <= 1'b1;
            end else if (cnt_in < thr) begin
                r_above <= 1'b0;
            end
        end
    end

    sat_updown_ctr #(
        .EPOCH_W (EPOCH_W)
    ) u_epoch (
        .clk   (clk),
        .rst   (rst),
        .i_clr (clr),
        .i_inc (w_wrap_up_nxt),
        .i_dec (w_wrap_dn_nxt),
        .o_val (epoch)
    );

    assign valid    = r_valid;
    assign dir      = r_dir;
    assign stall    = r_stall;
    assign wrap_up  = r_wrap_up;
    assign wrap_dn  = r_wrap_dn;
    assign jump_err = r_jump_err;
    assign above    = r_above;

endmodule

`default_nettype wire

// File: tb/tb_count_wrap_monitor.sv
// ============================================================================
// Module : tb_count_wrap_monitor
// Brief  : Self-checking bench for count_wrap_monitor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_count_wrap_monitor;

    typedef struct {
        logic [3:0] cnt;
        logic [3:0] thr;
        logic       clr;
        logic       valid;
        logic       dir;
        logic       stall;
        logic       wu;
        logic       wd;
        logic       jerr;
        int         epoch;
        logic       above;
    } vec_t;

    logic              clk;
    logic              rst;
    logic [3:0]        cnt_in;
    logic              clr;
    logic [3:0]        thr;
    logic              valid;
    logic              dir;
    logic              stall;
    logic              wrap_up;
    logic              wrap_dn;
    logic              jump_err;
    logic signed [7:0] epoch;
    logic              above;

    int   checks;
    int   errors;
    vec_t q[$];
    vec_t tbl[27];

    // Reference model state
    logic       m_primed;
    logic [3:0] m_prev;
    logic       m_valid, m_dir, m_stall, m_wu, m_wd, m_jerr, m_above;
    int         m_epoch;

    count_wrap_monitor #(
        .W       (4),
        .EPOCH_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cnt_in   (cnt_in),
        .clr      (clr),
        .thr      (thr),
        .valid    (valid),
        .dir      (dir),
        .stall    (stall),
        .wrap_up  (wrap_up),
        .wrap_dn  (wrap_dn),
        .jump_err (jump_err),
        .epoch    (epoch),
        .above    (above)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] c, input logic [3:0] t, input logic cl,
                                input logic v, input logic d, input logic s, input logic u,
                                input logic dn, input logic j, input int e, input logic a);
        vec_t r;
        r.cnt = c; r.thr = t; r.clr = cl; r.valid = v; r.dir = d; r.stall = s;
        r.wu = u; r.wd = dn; r.jerr = j; r.epoch = e; r.above = a;
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %0d expected %0d", nm, idx, got, exp);
        end
    endtask

    task automatic pop_check(input int idx);
        vec_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty step %0d got 0 expected 1", idx);
        end else begin
            e = q.pop_front();
            chk("valid",    idx, 32'(valid),    32'(e.valid));
            chk("dir",      idx, 32'(dir),      32'(e.dir));
            chk("stall",    idx, 32'(stall),    32'(e.stall));
            chk("wrap_up",  idx, 32'(wrap_up),  32'(e.wu));
            chk("wrap_dn",  idx, 32'(wrap_dn),  32'(e.wd));
            chk("jump_err", idx, 32'(jump_err), 32'(e.jerr));
            chk("epoch",    idx, $signed(epoch), e.epoch);
            chk("above",    idx, 32'(above),    32'(e.above));
        end
    endtask

    // Called at a falling edge: drive, queue expectation, clock, compare.
    task automatic apply(input vec_t v, input int idx);
        cnt_in = v.cnt;
        thr    = v.thr;
        clr    = v.clr;
        q.push_back(v);
        @(posedge clk);
        #1;
        pop_check(idx);
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic model_clear();
        m_primed = 1'b0; m_prev = 4'd0; m_valid = 1'b0; m_dir = 1'b1; m_stall = 1'b0;
        m_wu = 1'b0; m_wd = 1'b0; m_jerr = 1'b0; m_epoch = 0; m_above = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] c, input logic [3:0] t, input logic cl);
        logic [3:0] d;
        if (cl) begin
            model_clear();
        end else if (!m_primed) begin
            m_primed = 1'b1; m_valid = 1'b1; m_prev = c; m_above = (c > t);
            m_stall = 1'b0; m_wu = 1'b0; m_wd = 1'b0;
        end else begin
            d = c - m_prev;
            m_stall = 1'b0; m_wu = 1'b0; m_wd = 1'b0;
            if (d == 4'd1) begin
                m_dir = 1'b1; m_wu = (m_prev == 4'd15);
            end else if (d == 4'd15) begin
                m_dir = 1'b0; m_wd = (m_prev == 4'd0);
            end else if (d == 4'd0) begin
                m_stall = 1'b1;
            end else begin
                m_jerr = 1'b1;
            end
            if (m_wu && m_epoch < 127) m_epoch++;
            if (m_wd && m_epoch > -128) m_epoch--;
            if (c > t) m_above = 1'b1;
            else if (c < t) m_above = 1'b0;
            m_prev = c;
        end
    endtask

    function automatic vec_t model_vec(input logic [3:0] c, input logic [3:0] t, input logic cl);
        return mk(c, t, cl, m_valid, m_dir, m_stall, m_wu, m_wd, m_jerr, m_epoch, m_above);
    endfunction

    task automatic apply_model(input logic [3:0] c, input logic [3:0] t, input logic cl,
                               input int idx);
        model_step(c, t, cl);
        apply(model_vec(c, t, cl), idx);
    endtask

    initial begin
        logic [3:0] cur;
        checks = 0;
        errors = 0;
        rst = 1'b1; clr = 1'b0; cnt_in = 4'd0; thr = 4'd0;
        model_clear();

        // Reset state, before and across a clock edge
        #1;
        q.push_back(model_vec(4'd0, 4'd0, 1'b0));
        pop_check(-1);
        @(posedge clk); #1;
        q.push_back(model_vec(4'd0, 4'd0, 1'b0));
        pop_check(-2);
        @(negedge clk);
        rst = 1'b0;

        //           cnt thr clr  val dir stl wu wd jer ep abv
        tbl[0]  = mk(3,  4, 0,   1, 1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(4,  4, 0,   1, 1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(5,  4, 0,   1, 1, 0, 0, 0, 0, 0, 1);
        tbl[3]  = mk(0,  4, 1,   0, 1, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(14, 4, 0,   1, 1, 0, 0, 0, 0, 0, 1);
        tbl[5]  = mk(15, 4, 0,   1, 1, 0, 0, 0, 0, 0, 1);
        tbl[6]  = mk(0,  4, 0,   1, 1, 0, 1, 0, 0, 1, 0);
        tbl[7]  = mk(1,  4, 0,   1, 1, 0, 0, 0, 0, 1, 0);
        tbl[8]  = mk(0,  4, 0,   1, 0, 0, 0, 0, 0, 1, 0);
        tbl[9]  = mk(15, 4, 0,   1, 0, 0, 0, 1, 0, 0, 1);
        tbl[10] = mk(0,  4, 1,   0, 1, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(6,  4, 0,   1, 1, 0, 0, 0, 0, 0, 1);
        tbl[12] = mk(7,  4, 0,   1, 1, 0, 0, 0, 0, 0, 1);
        tbl[13] = mk(7,  4, 0,   1, 1, 1, 0, 0, 0, 0, 1);
        tbl[14] = mk(7,  4, 0,   1, 1, 1, 0, 0, 0, 0, 1);
        tbl[15] = mk(6,  4, 0,   1, 0, 0, 0, 0, 0, 0, 1);
        tbl[16] = mk(5,  4, 0,   1, 0, 0, 0, 0, 0, 0, 1);
        tbl[17] = mk(4,  4, 0,   1, 0, 0, 0, 0, 0, 0, 1);
        tbl[18] = mk(3,  4, 0,   1, 0, 0, 0, 0, 0, 0, 0);
        tbl[19] = mk(2,  4, 0,   1, 0, 0, 0, 0, 0, 0, 0);
        tbl[20] = mk(9,  4, 0,   1, 0, 0, 0, 0, 1, 0, 1);
        tbl[21] = mk(10, 4, 0,   1, 1, 0, 0, 0, 1, 0, 1);
        tbl[22] = mk(11, 4, 0,   1, 1, 0, 0, 0, 1, 0, 1);
        tbl[23] = mk(0,  4, 1,   0, 1, 0, 0, 0, 0, 0, 0);
        tbl[24] = mk(3,  4, 0,   1, 1, 0, 0, 0, 0, 0, 0);
        tbl[25] = mk(4,  3, 0,   1, 1, 0, 0, 0, 0, 0, 1);
        tbl[26] = mk(4, 15, 0,   1, 1, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 27; i++) begin
            apply(tbl[i], i);
        end

        // Epoch saturation: 130 up-wraps then 300 down-wraps, thr=0
        model_clear();
        apply_model(4'd0, 4'd0, 1'b1, 100);
        apply_model(4'd0, 4'd0, 1'b0, 101);
        cur = 4'd0;
        for (int w = 0; w < 130; w++) begin
            for (int k = 0; k < 16; k++) begin
                cur = cur + 4'd1;
                apply_model(cur, 4'd0, 1'b0, 1000 + w);
            end
        end
        chk("epoch_sat_max", 200, $signed(epoch), 127);
        for (int w = 0; w < 300; w++) begin
            for (int k = 0; k < 16; k++) begin
                cur = cur - 4'd1;
                apply_model(cur, 4'd0, 1'b0, 5000 + w);
            end
        end
        chk("epoch_sat_min", 201, $signed(epoch), -128);

        // Async reset landing inside a 15->0 transition
        apply_model(4'd0, 4'd4, 1'b1, 300);
        apply_model(4'd14, 4'd4, 1'b0, 301);
        apply_model(4'd15, 4'd4, 1'b0, 302);
        cur = 4'd15;
        for (int k = 0; k < 16; k++) begin
            cur = cur + 4'd1;
            apply_model(cur, 4'd4, 1'b0, 310 + k);
        end
        chk("epoch_pre_rst", 330, $signed(epoch), 1);
        cnt_in = 4'd0;
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        q.push_back(model_vec(4'd0, 4'd4, 1'b0));
        pop_check(331);
        @(posedge clk); #1;
        q.push_back(model_vec(4'd0, 4'd4, 1'b0));
        pop_check(332);
        @(negedge clk);
        rst = 1'b0;
        apply_model(4'd0, 4'd4, 1'b0, 333);
        apply_model(4'd1, 4'd4, 1'b0, 334);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
